dlf_gear_ctrl: RTL and testbench
================================

// Module: dlf_gear_ctrl
// PURPOSE
//  Bandwidth-gearing sequencer for the type-II DLF (prop/int path + 2x IIR + 1st-order DSM).
//  Runs the loop wide for acquisition, then steps KPS/KIS down to tracking values,
//  enables IIR1, IIR2 and the DSM in order, and flags lock from bang-bang PDE toggle density.
//  Sits beside the DLF in the CKVD domain and drives all of its config inputs.
// PARAMETERS
//  CNT_W      16       width of the dwell/gear timers and of ACQ_CYC/GEAR_CYC
//  LWIN_W     6        lock window = 2**LWIN_W CKVD cycles
//  KIIR1S_VAL 6'h3D    KIIR1S driven to the DLF (-3, signed shift)
//  KIIR2S_VAL 6'h3D    KIIR2S driven to the DLF (-3, signed shift)
// PORTS
//  CKVD      in   1       divided-clock, all logic on posedge
//  NRST      in   1       reset, asynchronous, active-low
//  START     in   1       level; 1 = run sequence, 0 = return to IDLE
//  PDE       in   1       bang-bang phase detector output
//  KPS_ACQ   in   6       signed acquisition proportional shift
//  KIS_ACQ   in   6       signed acquisition integral shift
//  KPS_TRK   in   6       signed tracking proportional shift
//  KIS_TRK   in   6       signed tracking integral shift
//  ACQ_CYC   in   CNT_W   ACQ dwell in cycles (0 treated as 1)
//  GEAR_CYC  in   CNT_W   cycles per gear step / per IIR stage (0 treated as 1)
//  LOCK_TH   in   LWIN_W+1  PDE toggles per window required for lock
//  DLFEN     out  1       DLF accumulate enable
//  KPS,KIS   out  6       current signed shifts to the DLF
//  KIIR1S,KIIR2S out 6    constant = KIIR1S_VAL / KIIR2S_VAL
//  IIR1EN,IIR2EN,DSM1STEN out 1  DLF stage enables
//  LOCK      out  1       lock flag
//  STATE     out  3       FSM state code
// BEHAVIOUR
//  - All outputs registered. Reset: STATE=IDLE, DLFEN=0, IIR1EN=IIR2EN=DSM1STEN=0, LOCK=0,
//    KPS=KIS=0, timers and lock counters 0.
//  - States: IDLE=0, ACQ=1, SHIFT=2, IIR=3, TRACK=4. Codes 5-7 are illegal -> IDLE next cycle.
//  - IDLE: DLFEN=0, all enables 0. START=1 -> ACQ next edge, loading KPS=KPS_ACQ, KIS=KIS_ACQ,
//    DLFEN=1, timer cleared.
//  - ACQ: timer counts each cycle; at timer==ACQ_CYC-1 -> SHIFT, timer cleared.
//  - SHIFT: every GEAR_CYC cycles one gear step (signed compare):
//    KPS <= (KPS-1 < KPS_TRK) ? KPS_TRK : KPS-1; KIS <= (KIS-2 < KIS_TRK) ? KIS_TRK : KIS-2.
//    A field already <= its target is loaded with the target on that step.
//    When both equal their targets after a step -> IIR. Minimum SHIFT dwell = GEAR_CYC.
//  - IIR: IIR1EN=1 on entry; after GEAR_CYC cycles IIR2EN=1; after GEAR_CYC more
//    -> TRACK with DSM1STEN=1.
//  - TRACK: holds all config; stays until START=0.
//  - START=0 in any non-IDLE state -> IDLE next edge, outputs to reset values.
//    START re-asserted restarts from ACQ.
//  - Lock detector: counts cycles where PDE != previous PDE, over consecutive windows of
//    2**LWIN_W cycles, active only in TRACK. At window end, LOCK <= (count >= LOCK_TH)
//    and the count restarts. LOCK=0 outside TRACK. The window counter restarts on TRACK entry.
//  - No wrap: timers saturate; the toggle counter is LWIN_W+1 bits and cannot overflow.
//  - Async NRST mid-sequence -> immediate reset values; the FSM waits in IDLE for START.
// CONFIGURATION
//  DLF_GEAR_RELOCK_EN defined: in TRACK, a window ending with LOCK=1 then count < LOCK_TH/2
//    (loss of lock) -> ACQ next edge, reloading the ACQ shifts. IIR1EN, IIR2EN, DSM1STEN
//    and LOCK are cleared.
//  Not defined: TRACK is left only via START=0; LOCK simply deasserts on loss.
// TESTING
//  1 ACQ_CYC=4,GEAR_CYC=2,KPS 3->0,KIS 2->-4,START=1 -> KPS 3,2,1,0 / KIS 2,0,-2,-4 every 2 cyc,
//    IIR1EN, +2 IIR2EN, +2 DSM1STEN.
//  2 KIS_TRK=-3 from KIS_ACQ=2 -> KIS 2,0,-2,-3 (saturates to target, no undershoot).
//  3 KPS_ACQ=KPS_TRK, KIS_ACQ=KIS_TRK -> exactly one SHIFT step (GEAR_CYC cycles), then IIR.
//  4 TRACK, LWIN_W=6, PDE toggles every cycle, LOCK_TH=40 -> LOCK=1 at first window end;
//    PDE held constant -> LOCK=0 next window.
//  5 START=0 in SHIFT and NRST pulse in IIR -> all outputs reset next edge / immediately;
//    START=1 restarts at KPS_ACQ.
//  6 DLF_GEAR_RELOCK_EN: lock, then constant PDE -> STATE=ACQ, KPS=KPS_ACQ, enables 0;
//    without the macro STATE stays TRACK.

Source files
------------

// File: rtl/dlf_gear_ctrl.sv
// rtl/dlf_gear_ctrl.sv - bandwidth-gearing sequencer and lock detector for the type-II DLF
// Optional macro DLF_GEAR_RELOCK_EN: loss of lock in TRACK restarts acquisition.
module dlf_gear_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LWIN_W     = 6,
  parameter logic [5:0]  KIIR1S_VAL = 6'h3D,
  parameter logic [5:0]  KIIR2S_VAL = 6'h3D
) (
  input  logic              CKVD,
  input  logic              NRST,
  input  logic              START,
  input  logic              PDE,
  input  logic [5:0]        KPS_ACQ,
  input  logic [5:0]        KIS_ACQ,
  input  logic [5:0]        KPS_TRK,
  input  logic [5:0]        KIS_TRK,
  input  logic [CNT_W-1:0]  ACQ_CYC,
  input  logic [CNT_W-1:0]  GEAR_CYC,
  input  logic [LWIN_W:0]   LOCK_TH,
  output logic              DLFEN,
  output logic [5:0]        KPS,
  output logic [5:0]        KIS,
  output logic [5:0]        KIIR1S,
  output logic [5:0]        KIIR2S,
  output logic              IIR1EN,
  output logic              IIR2EN,
  output logic              DSM1STEN,
  output logic              LOCK,
  output logic [2:0]        STATE
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ACQ   = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_IIR   = 3'd3;
  localparam logic [2:0] ST_TRACK = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  tmr_q, tmr_d;
  logic              dlfen_q, dlfen_d;
  logic [5:0]        kps_q, kps_d;
  logic [5:0]        kis_q, kis_d;
  logic              iir1en_q, iir1en_d;
  logic              iir2en_q, iir2en_d;
  logic              dsm_q, dsm_d;
  logic              lock_q, lock_d;
  logic              pde_q, pde_d;
  logic [LWIN_W-1:0] win_q, win_d;
  logic [LWIN_W:0]   tog_q, tog_d;

  logic [CNT_W-1:0]  acq_end, gear_end, tmr_inc;
  logic              acq_last, gear_last;
  logic signed [6:0] kps_m1, kis_m2, kps_trk_x, kis_trk_x;
  logic [5:0]        kps_step, kis_step;
  logic              shift_done;
  logic [LWIN_W:0]   tog_sum;
  logic              win_end, lock_hit, relock;

  // A zero dwell behaves as a one-cycle dwell.
  assign acq_end   = (ACQ_CYC == '0)  ? '0 : ACQ_CYC - 1'b1;
  assign gear_end  = (GEAR_CYC == '0) ? '0 : GEAR_CYC - 1'b1;
  assign acq_last  = (tmr_q == acq_end);
  assign gear_last = (tmr_q == gear_end);
  assign tmr_inc   = (&tmr_q) ? tmr_q : tmr_q + 1'b1;

  // Gear arithmetic is done one bit wider so a step below -32 cannot wrap.
  assign kps_m1     = $signed({kps_q[5], kps_q}) - 7'sd1;
  assign kis_m2     = $signed({kis_q[5], kis_q}) - 7'sd2;
  assign kps_trk_x  = $signed({KPS_TRK[5], KPS_TRK});
  assign kis_trk_x  = $signed({KIS_TRK[5], KIS_TRK});
  assign kps_step   = (kps_m1 < kps_trk_x) ? KPS_TRK : kps_m1[5:0];
  assign kis_step   = (kis_m2 < kis_trk_x) ? KIS_TRK : kis_m2[5:0];
  assign shift_done = gear_last && (kps_step == KPS_TRK) && (kis_step == KIS_TRK);

  assign tog_sum  = tog_q + {{LWIN_W{1'b0}}, PDE ^ pde_q};
  assign win_end  = &win_q;
  assign lock_hit = (tog_sum >= LOCK_TH);

`ifdef DLF_GEAR_RELOCK_EN
  assign relock = (state_q == ST_TRACK) && win_end && lock_q &&
                  (tog_sum < {1'b0, LOCK_TH[LWIN_W:1]});
`else
  assign relock = 1'b0;
`endif

  always_ff @(posedge CKVD or negedge NRST) begin
    if (!NRST) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      dlfen_q  <= 1'b0;
      kps_q    <= '0;
      kis_q    <= '0;
      iir1en_q <= 1'b0;
      iir2en_q <= 1'b0;
      dsm_q    <= 1'b0;
      lock_q   <= 1'b0;
      pde_q    <= 1'b0;
      win_q    <= '0;
      tog_q    <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      dlfen_q  <= dlfen_d;
      kps_q    <= kps_d;
      kis_q    <= kis_d;
      iir1en_q <= iir1en_d;
      iir2en_q <= iir2en_d;
      dsm_q    <= dsm_d;
      lock_q   <= lock_d;
      pde_q    <= pde_d;
      win_q    <= win_d;
      tog_q    <= tog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!START) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ACQ;
        ST_ACQ:   if (acq_last) state_d = ST_SHIFT;
        ST_SHIFT: if (shift_done) state_d = ST_IIR;
        ST_IIR:   if (gear_last && iir2en_q) state_d = ST_TRACK;
        ST_TRACK: if (relock) state_d = ST_ACQ;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tmr_d    = tmr_inc;
    dlfen_d  = dlfen_q;
    kps_d    = kps_q;
    kis_d    = kis_q;
    iir1en_d = iir1en_q;
    iir2en_d = iir2en_q;
    dsm_d    = dsm_q;
    lock_d   = 1'b0;
    pde_d    = PDE;
    win_d    = '0;
    tog_d    = '0;
    case (state_q)
      ST_IDLE: begin
        tmr_d    = '0;
        dlfen_d  = 1'b1;
        kps_d    = KPS_ACQ;
        kis_d    = KIS_ACQ;
        iir1en_d = 1'b0;
        iir2en_d = 1'b0;
        dsm_d    = 1'b0;
      end
      ST_ACQ: begin
        if (acq_last) tmr_d = '0;
      end
      ST_SHIFT: begin
        if (gear_last) begin
          tmr_d    = '0;
          kps_d    = kps_step;
          kis_d    = kis_step;
          iir1en_d = shift_done;
        end
      end
      ST_IIR: begin
        if (gear_last) begin
          tmr_d = '0;
          if (iir2en_q) dsm_d = 1'b1;
          else          iir2en_d = 1'b1;
        end
      end
      ST_TRACK: begin
        tmr_d  = '0;
        win_d  = win_q + 1'b1;
        tog_d  = win_end ? '0 : tog_sum;
        lock_d = win_end ? lock_hit : lock_q;
        if (relock) begin
          kps_d    = KPS_ACQ;
          kis_d    = KIS_ACQ;
          iir1en_d = 1'b0;
          iir2en_d = 1'b0;
          dsm_d    = 1'b0;
          lock_d   = 1'b0;
          win_d    = '0;
          tog_d    = '0;
        end
      end
      default: ;
    endcase
    // Dropping START (or landing on an illegal code) returns every output to reset.
    if (!START || (state_q > ST_TRACK)) begin
      tmr_d    = '0;
      dlfen_d  = 1'b0;
      kps_d    = '0;
      kis_d    = '0;
      iir1en_d = 1'b0;
      iir2en_d = 1'b0;
      dsm_d    = 1'b0;
      lock_d   = 1'b0;
      win_d    = '0;
      tog_d    = '0;
    end
  end

  assign STATE    = state_q;
  assign DLFEN    = dlfen_q;
  assign KPS      = kps_q;
  assign KIS      = kis_q;
  assign KIIR1S   = KIIR1S_VAL;
  assign KIIR2S   = KIIR2S_VAL;
  assign IIR1EN   = iir1en_q;
  assign IIR2EN   = iir2en_q;
  assign DSM1STEN = dsm_q;
  assign LOCK     = lock_q;

endmodule

// File: tb/tb_dlf_gear_ctrl.sv
// tb/tb_dlf_gear_ctrl.sv - scoreboard bench for dlf_gear_ctrl against a timeline model
`timescale 1ns/1ps
module tb_dlf_gear_ctrl;

  localparam int CNT_W  = 16;
  localparam int LWIN_W = 6;
  localparam int WIN    = 1 << LWIN_W;
  localparam logic [5:0] KIIR_EXP = 6'h3D;
`ifdef DLF_GEAR_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  logic              CKVD = 1'b0;
  logic              NRST = 1'b0;
  logic              START = 1'b0;
  logic              PDE = 1'b0;
  logic [5:0]        KPS_ACQ = '0, KIS_ACQ = '0, KPS_TRK = '0, KIS_TRK = '0;
  logic [CNT_W-1:0]  ACQ_CYC = '0, GEAR_CYC = '0;
  logic [LWIN_W:0]   LOCK_TH = '0;
  logic              DLFEN, IIR1EN, IIR2EN, DSM1STEN, LOCK;
  logic [5:0]        KPS, KIS, KIIR1S, KIIR2S;
  logic [2:0]        STATE;

  dlf_gear_ctrl #(.CNT_W(CNT_W), .LWIN_W(LWIN_W)) dut (
    .CKVD(CKVD), .NRST(NRST), .START(START), .PDE(PDE),
    .KPS_ACQ(KPS_ACQ), .KIS_ACQ(KIS_ACQ), .KPS_TRK(KPS_TRK), .KIS_TRK(KIS_TRK),
    .ACQ_CYC(ACQ_CYC), .GEAR_CYC(GEAR_CYC), .LOCK_TH(LOCK_TH),
    .DLFEN(DLFEN), .KPS(KPS), .KIS(KIS), .KIIR1S(KIIR1S), .KIIR2S(KIIR2S),
    .IIR1EN(IIR1EN), .IIR2EN(IIR2EN), .DSM1STEN(DSM1STEN), .LOCK(LOCK), .STATE(STATE)
  );

  always #5 CKVD = ~CKVD;

  typedef struct packed {
    logic [2:0] st;
    logic       dlfen;
    logic [5:0] kps;
    logic [5:0] kis;
    logic       i1;
    logic       i2;
    logic       dsm;
    logic       lock;
  } exp_t;

  exp_t sb_q[$];
  exp_t sched[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   prev_pde = 1'b0;
  int   trk_n = 0;
  int   trk_sum = 0;

  function automatic int sx6(input logic [5:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string tag, input exp_t e);
    logic [31:0] act, expv;
    act  = {STATE, DLFEN, KPS, KIS, IIR1EN, IIR2EN, DSM1STEN, LOCK, KIIR1S, KIIR2S};
    expv = {e, KIIR_EXP, KIIR_EXP};
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s t=%0t got st=%0d kps=%h kis=%h dlf/i1/i2/dsm/lk=%b%b%b%b%b kiir=%h/%h need st=%0d kps=%h kis=%h dlf/i1/i2/dsm/lk=%b%b%b%b%b kiir=%h",
               tag, $time, STATE, KPS, KIS, DLFEN, IIR1EN, IIR2EN, DSM1STEN, LOCK, KIIR1S, KIIR2S,
               e.st, e.kps, e.kis, e.dlfen, e.i1, e.i2, e.dsm, e.lock, KIIR_EXP);
    end
  endtask

  // Expected per-cycle timeline of one acquisition run, from the gearing rules.
  task automatic build_sched();
    int p, i, pt, it, ae, ge;
    exp_t r;
    sched.delete();
    ae = (ACQ_CYC == 0) ? 1 : int'(ACQ_CYC);
    ge = (GEAR_CYC == 0) ? 1 : int'(GEAR_CYC);
    p = sx6(KPS_ACQ); i = sx6(KIS_ACQ); pt = sx6(KPS_TRK); it = sx6(KIS_TRK);
    r = '0; r.dlfen = 1'b1;
    r.st = 3'd1; r.kps = KPS_ACQ; r.kis = KIS_ACQ;
    repeat (ae) sched.push_back(r);
    r.st = 3'd2;
    do begin
      r.kps = p[5:0]; r.kis = i[5:0];
      repeat (ge) sched.push_back(r);
      p = (p - 1 < pt) ? pt : p - 1;
      i = (i - 2 < it) ? it : i - 2;
    end while (!(p == pt && i == it));
    r.st = 3'd3; r.kps = p[5:0]; r.kis = i[5:0]; r.i1 = 1'b1;
    repeat (ge) sched.push_back(r);
    r.i2 = 1'b1;
    repeat (ge) sched.push_back(r);
  endtask

  task automatic model_edge();
    exp_t nx;
    bit tg;
    tg = (PDE != prev_pde);
    if (!START) begin
      nx = '0;
      sched.delete();
    end else if (cur.st == 3'd0) begin
      build_sched();
      nx = sched.pop_front();
    end else if (cur.st == 3'd4) begin
      nx = cur;
      trk_n++;
      trk_sum += int'(tg);
      if (trk_n % WIN == 0) begin
        if (RELOCK && cur.lock && trk_sum < int'(LOCK_TH) / 2) begin
          build_sched();
          nx = sched.pop_front();
        end else begin
          nx.lock = (trk_sum >= int'(LOCK_TH));
        end
        trk_sum = 0;
      end
    end else if (sched.size() > 0) begin
      nx = sched.pop_front();
    end else begin
      nx = cur; nx.st = 3'd4; nx.dsm = 1'b1; nx.lock = 1'b0;
      trk_n = 0; trk_sum = 0;
    end
    prev_pde = PDE;
    cur = nx;
  endtask

  task automatic tick(input bit st, input bit pd);
    @(negedge CKVD);
    START = st;
    PDE = pd;
    model_edge();
    sb_q.push_back(cur);
  endtask

  task automatic run(input int n, input int mode, input int drop_pct);
    bit p, s;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       p = 1'($urandom_range(0, 1));
        1:       p = ~PDE;
        default: p = PDE;
      endcase
      s = ($urandom_range(0, 99) >= drop_pct);
      tick(s, p);
    end
  endtask

  task automatic nrst_pulse();
    @(negedge CKVD);
    NRST = 1'b0;
    #1;
    check("async_reset", '0);
    cur = '0;
    sched.delete();
    prev_pde = 1'b0;
    sb_q.push_back(cur);
    @(posedge CKVD);
    #3;
    NRST = 1'b1;
  endtask

  task automatic set_cfg(input int acq, input int gear, input logic [5:0] pa, input logic [5:0] ia,
                         input logic [5:0] pt, input logic [5:0] it, input int th);
    ACQ_CYC = CNT_W'(acq); GEAR_CYC = CNT_W'(gear);
    KPS_ACQ = pa; KIS_ACQ = ia; KPS_TRK = pt; KIS_TRK = it;
    LOCK_TH = (LWIN_W + 1)'(th);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CKVD);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("cycle", e);
      end
    end
  end

  initial begin : stim
    cur = '0;
    nrst_pulse();
    tick(0, 0); tick(0, 0);

    set_cfg(4, 2, 6'd3, 6'd2, 6'd0, 6'h3C, 40);
    run(30, 0, 0);
    tick(0, 0); tick(0, 0);

    set_cfg(4, 2, 6'd3, 6'd2, 6'd0, 6'h3D, 40);
    run(30, 0, 0);
    tick(0, 0);

    set_cfg(3, 3, 6'h3E, 6'h3A, 6'h3E, 6'h3A, 40);
    run(20, 0, 0);
    tick(0, 0);

    set_cfg(4, 2, 6'd1, 6'd1, 6'd1, 6'd1, 40);
    run(10, 0, 0);
    run(WIN + 2, 1, 0);
    run(2 * WIN + 4, 2, 0);
    run(WIN, 1, 0);
    tick(0, 0);

    set_cfg(2, 3, 6'd5, 6'd2, 6'h3B, 6'd0, 40);
    run(5, 0, 0);
    tick(0, 0);
    set_cfg(2, 3, 6'd2, 6'd2, 6'd0, 6'd0, 40);
    run(10, 0, 0);
    nrst_pulse();
    run(20, 0, 0);
    tick(0, 0);

    set_cfg(0, 0, 6'h20, 6'h1F, 6'h1F, 6'h20, 0);
    run(20, 0, 0);
    tick(0, 0);

    for (int r = 0; r < 30; r++) begin
      set_cfg($urandom_range(0, 5), $urandom_range(0, 3),
              6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
              6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
              $urandom_range(0, 64));
      run($urandom_range(20, 250), $urandom_range(0, 2), (r % 3 == 0) ? 1 : 0);
      tick(0, 0);
    end

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge CKVD);
    #3;
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
